key_sw_capture: RTL and testbench
=================================

# key_sw_capture

Input-side front end for the DE10-Lite board designs: it synchronizes and debounces the two pushbuttons, then latches the slide-switch value as an operand for downstream logic. Downstream logic consumes the operand through a valid/ready handshake. The block sits between the board pins (KEY, SW) and the datapath that drives HEX/LEDR, and it is the input counterpart to the display/LED output path.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key change (10 ms at 50 MHz); must be ≥1.
- SW_WIDTH, 10, width of the switch operand.
- MAX10_CLK1_50  in  1  single clock for all logic.
- RESET_N  in  1  reset, synchronous, active-low.
- KEY  in  2  raw pushbuttons, active-low (0 = pressed), asynchronous to clock.
- SW  in  SW_WIDTH  raw slide switches, asynchronous.
- key_press  out  2  one-cycle pulse per debounced press, one bit per key.
- key_level  out  2  debounced key state, active-high (1 = held).
- data_out  out  SW_WIDTH  captured operand.
- data_valid  out  1  operand available.
- data_ready  in  1  consumer accepts operand when high with data_valid.
- overrun  out  1  sticky: a capture was dropped because the operand was not consumed.

## Operation
- Synchronizers: KEY and SW each pass through a 2-flop synchronizer. All logic below uses the synchronized values only.
- Per-key debounce FSM:
  - State is the stable level S (reset: released) plus counter C, width $clog2(DEBOUNCE_CYCLES+1), reset 0.
  - If the synced key equals S: C ← 0.
  - If it differs and C < DEBOUNCE_CYCLES−1: C ← C+1.
  - If it differs and C = DEBOUNCE_CYCLES−1: S flips and C ← 0.
- key_level = registered S.
- key_press[i] is a registered pulse, high for exactly one cycle on each released→held transition of S. Held→released produces no pulse.
- Any bounce (synced value returning to S) before the count completes clears C. No event is produced.
- KEY[1] press captures the synced SW.
- KEY[0] press acts as clear.
- Output FSM, EMPTY (data_valid=0) / FULL (data_valid=1):
  - EMPTY, capture: data_out ← SW, go to FULL.
  - FULL, data_ready=1, no capture: go to EMPTY. data_out holds its value.
  - FULL, data_ready=1, capture in the same cycle: data_out ← new SW, stay FULL, no overrun.
  - FULL, data_ready=0, capture: data_out unchanged, overrun ← 1.
  - Clear in either state: go to EMPTY, overrun ← 0. Clear has priority over a same-cycle capture (the capture is discarded) and over data_ready.
- data_out changes only on an accepted capture.

## Timing
- Reset values: key_press=0, key_level=0, data_out=0, data_valid=0, overrun=0. Synchronizers, counters and S are cleared to released.
- Reset asserted mid-count or mid-handshake discards the pending count and the operand.
- A key held low through reset release is debounced afresh and yields one press.
- Press latency: key_press rises DEBOUNCE_CYCLES+3 rising edges after the first edge at which KEY is sampled low, given KEY stays low. This is 2 cycles of synchronizer, DEBOUNCE_CYCLES of count, and 1 cycle of output register.
- data_valid and data_out update on the edge after the key_press pulse is generated internally, i.e. the same cycle key_press is visible at the port.
- The handshake completes on any edge with data_valid=1 and data_ready=1. data_valid falls on the following cycle unless a capture coincides.
- data_ready is ignored while data_valid=0.
- Both keys are fully independent. Simultaneous presses are resolved by the clear-priority rule.

## Test plan
- DEBOUNCE_CYCLES=4, reset, then KEY=2'b01 held, SW=10'h2A5 → key_press[1] high for exactly 1 cycle at edge 7 after the first low sample; data_out=10'h2A5, data_valid=1, key_level[1]=1.
- KEY[1] bounces low for 3 cycles then high, repeated 5 times → no key_press, data_valid stays 0, key_level stays 0.
- Capture 10'h0F0 with data_ready=0, then second press with SW=10'h3FF → data_out stays 10'h0F0, overrun=1. Then KEY[0] press → data_valid=0, overrun=0.
- data_valid=1, data_ready=1 in the same cycle as a new capture of 10'h155 → data_out=10'h155, data_valid stays 1, overrun stays 0.
- Both keys reach the debounced press on the same cycle with data_valid=1 → data_valid=0, data_out unchanged, overrun=0.
- RESET_N low for 1 cycle mid-debounce with KEY[1] held and data_valid=1 → all outputs 0 on the next cycle. One fresh key_press[1] arrives DEBOUNCE_CYCLES+3 cycles after reset release.

Source files
------------

// File: rtl/key_sw_capture.sv
// rtl/key_sw_capture.sv - synchronizes and debounces KEY, captures SW as a valid/ready operand
// KEY[1] press captures the switches, KEY[0] press clears the operand and overrun flag.
module key_sw_capture #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SW_WIDTH        = 10
) (
   input  logic                MAX10_CLK1_50,
   input  logic                RESET_N,
   input  logic [1:0]          KEY,
   input  logic [SW_WIDTH-1:0] SW,
   output logic [1:0]          key_press,
   output logic [1:0]          key_level,
   output logic [SW_WIDTH-1:0] data_out,
   output logic                data_valid,
   input  logic                data_ready,
   output logic                overrun
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {EMPTY, FULL} state_t;

   logic [1:0]          key_meta;
   logic [1:0]          key_sync;
   logic [SW_WIDTH-1:0] sw_meta;
   logic [SW_WIDTH-1:0] sw_sync;
   logic [1:0]          stable;
   logic [CW-1:0]       cnt [2];
   logic [1:0]          press_evt;
   logic                capture;
   logic                clear;
   state_t              state;

   always_ff @(posedge MAX10_CLK1_50) begin
      if (!RESET_N) begin
         key_meta <= 2'b11;
         key_sync <= 2'b11;
         sw_meta  <= '0;
         sw_sync  <= '0;
      end else begin
         key_meta <= KEY;
         key_sync <= key_meta;
         sw_meta  <= SW;
         sw_sync  <= sw_meta;
      end
   end

   // stable is active-high (1 = held); key_sync is active-low from the pins
   always_ff @(posedge MAX10_CLK1_50) begin
      if (!RESET_N) begin
         stable <= '0;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (~key_sync[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == C_LAST) begin
               stable[i] <= ~stable[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   assign press_evt = stable & ~key_level;
   assign capture   = press_evt[1];
   assign clear     = press_evt[0];

   always_ff @(posedge MAX10_CLK1_50) begin
      if (!RESET_N) begin
         key_level <= '0;
         key_press <= '0;
      end else begin
         key_level <= stable;
         key_press <= press_evt;
      end
   end

   // clear wins over a same-cycle capture and over data_ready
   always_ff @(posedge MAX10_CLK1_50) begin
      if (!RESET_N) begin
         state      <= EMPTY;
         data_valid <= 1'b0;
         data_out   <= '0;
         overrun    <= 1'b0;
      end else if (clear) begin
         state      <= EMPTY;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (capture) begin
                  data_out   <= sw_sync;
                  state      <= FULL;
                  data_valid <= 1'b1;
               end
            end
            FULL: begin
               if (capture && data_ready) begin
                  data_out <= sw_sync;
               end else if (capture) begin
                  overrun <= 1'b1;
               end else if (data_ready) begin
                  state      <= EMPTY;
                  data_valid <= 1'b0;
               end
            end
            default: begin
               state      <= EMPTY;
               data_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_sw_capture.sv
// tb/tb_key_sw_capture.sv - directed bench for key_sw_capture with DEBOUNCE_CYCLES=4
// Observed word per check: {key_press, key_level, data_valid, overrun, data_out}.
module tb_key_sw_capture;

   logic       clk = 1'b0;
   logic       resetn;
   logic [1:0] key;
   logic [9:0] sw;
   logic [1:0] key_press;
   logic [1:0] key_level;
   logic [9:0] data_out;
   logic       data_valid;
   logic       data_ready;
   logic       overrun;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [1:0]  key;
      logic [9:0]  sw;
      logic        rdy;
      int          cyc;
      logic [15:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   key_sw_capture #(.DEBOUNCE_CYCLES(4), .SW_WIDTH(10)) dut (
      .MAX10_CLK1_50(clk),
      .RESET_N      (resetn),
      .KEY          (key),
      .SW           (sw),
      .key_press    (key_press),
      .key_level    (key_level),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .data_ready   (data_ready),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] pk(logic [1:0] p, logic [1:0] l, logic v, logic o, logic [9:0] d);
      return {p, l, v, o, d};
   endfunction

   function automatic logic [15:0] obs();
      return {key_press, key_level, data_valid, overrun, data_out};
   endfunction

   task automatic step(int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(string name, logic [15:0] act, logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   initial begin
      // press timing: pulse 7 edges after the first low sample
      vecs.push_back('{2'b01, 10'h2A5, 1'b0, 6, pk(2'b00, 2'b00, 0, 0, 10'h000), "press_edge6"});
      vecs.push_back('{2'b01, 10'h2A5, 1'b0, 1, pk(2'b10, 2'b10, 1, 0, 10'h2A5), "press_edge7"});
      vecs.push_back('{2'b01, 10'h2A5, 1'b0, 1, pk(2'b00, 2'b10, 1, 0, 10'h2A5), "press_edge8"});
      vecs.push_back('{2'b11, 10'h2A5, 1'b0, 8, pk(2'b00, 2'b00, 1, 0, 10'h2A5), "release1"});
      vecs.push_back('{2'b10, 10'h2A5, 1'b0, 7, pk(2'b01, 2'b01, 0, 0, 10'h2A5), "clear_a"});
      vecs.push_back('{2'b11, 10'h2A5, 1'b0, 8, pk(2'b00, 2'b00, 0, 0, 10'h2A5), "release0_a"});
      // overrun: second capture while not consumed
      vecs.push_back('{2'b01, 10'h0F0, 1'b0, 7, pk(2'b10, 2'b10, 1, 0, 10'h0F0), "cap_0f0"});
      vecs.push_back('{2'b11, 10'h0F0, 1'b0, 8, pk(2'b00, 2'b00, 1, 0, 10'h0F0), "rel_0f0"});
      vecs.push_back('{2'b01, 10'h3FF, 1'b0, 7, pk(2'b10, 2'b10, 1, 1, 10'h0F0), "overrun_set"});
      vecs.push_back('{2'b11, 10'h3FF, 1'b0, 8, pk(2'b00, 2'b00, 1, 1, 10'h0F0), "overrun_sticky"});
      vecs.push_back('{2'b10, 10'h3FF, 1'b0, 7, pk(2'b01, 2'b01, 0, 0, 10'h0F0), "clear_overrun"});
      vecs.push_back('{2'b11, 10'h3FF, 1'b1, 8, pk(2'b00, 2'b00, 0, 0, 10'h0F0), "empty_ignores_rdy"});
      // handshake coinciding with a new capture
      vecs.push_back('{2'b01, 10'h111, 1'b0, 7, pk(2'b10, 2'b10, 1, 0, 10'h111), "cap_111"});
      vecs.push_back('{2'b11, 10'h111, 1'b0, 8, pk(2'b00, 2'b00, 1, 0, 10'h111), "rel_111"});
      vecs.push_back('{2'b01, 10'h155, 1'b0, 6, pk(2'b00, 2'b00, 1, 0, 10'h111), "pre_155"});
      vecs.push_back('{2'b01, 10'h155, 1'b1, 1, pk(2'b10, 2'b10, 1, 0, 10'h155), "rdy_and_cap"});
      vecs.push_back('{2'b01, 10'h155, 1'b1, 1, pk(2'b00, 2'b10, 0, 0, 10'h155), "handshake_done"});
      vecs.push_back('{2'b11, 10'h155, 1'b0, 8, pk(2'b00, 2'b00, 0, 0, 10'h155), "rel_155"});
      // simultaneous presses: clear wins
      vecs.push_back('{2'b01, 10'h0AA, 1'b0, 7, pk(2'b10, 2'b10, 1, 0, 10'h0AA), "cap_0aa"});
      vecs.push_back('{2'b11, 10'h0AA, 1'b0, 8, pk(2'b00, 2'b00, 1, 0, 10'h0AA), "rel_0aa"});
      vecs.push_back('{2'b00, 10'h3C3, 1'b0, 7, pk(2'b11, 2'b11, 0, 0, 10'h0AA), "both_keys"});
      vecs.push_back('{2'b11, 10'h3C3, 1'b0, 8, pk(2'b00, 2'b00, 0, 0, 10'h0AA), "rel_both"});

      resetn     = 1'b0;
      key        = 2'b11;
      sw         = '0;
      data_ready = 1'b0;
      step(3);
      check("reset_state", obs(), pk(2'b00, 2'b00, 0, 0, 10'h000));
      resetn = 1'b1;

      foreach (vecs[i]) begin
         key        = vecs[i].key;
         sw         = vecs[i].sw;
         data_ready = vecs[i].rdy;
         step(vecs[i].cyc);
         check(vecs[i].name, obs(), vecs[i].exp);
      end

      // bounce: 3 low samples never complete a count of 4
      for (int r = 0; r < 5; r++) begin
         key = 2'b01;
         for (int c = 0; c < 3; c++) begin
            step(1);
            check("bounce_low", {14'h0, key_press}, 16'h0);
         end
         key = 2'b11;
         step(1);
         check("bounce_high", {14'h0, key_press}, 16'h0);
      end
      step(4);
      check("bounce_end", obs(), pk(2'b00, 2'b00, 0, 0, 10'h0AA));

      // reset mid-debounce with an operand pending
      sw  = 10'h201;
      key = 2'b01;
      step(7);
      check("rst_pre_cap", obs(), pk(2'b10, 2'b10, 1, 0, 10'h201));
      key = 2'b11;
      step(8);
      key = 2'b01;
      sw  = 10'h099;
      step(3);
      resetn = 1'b0;
      step(1);
      check("rst_clears", obs(), pk(2'b00, 2'b00, 0, 0, 10'h000));
      resetn = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         step(1);
         if (c < 7) check("rst_no_early_press", {14'h0, key_press}, 16'h0);
         else       check("rst_fresh_press", obs(), pk(2'b10, 2'b10, 1, 0, 10'h099));
      end
      step(1);
      check("rst_press_single", {14'h0, key_press}, 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
